native_mem_model: RTL and testbench

Parametrised memory and MMIO slave for the picorv32 native memory interface, used as the standard memory model in core-level benches and in small FPGA builds. Serves word-addressed RAM with byte-lane writes, inserts a configurable number of wait states through a small handshake FSM, and flags out-of-range accesses. Optionally decodes a memory-mapped IO window providing a console output port, a cycle counter and a done flag.

---
 rtl/native_mem_model_if.sv | 21 ++
 rtl/native_mem_model.sv | 150 +++++++++++++++
 tb/tb_native_mem_model.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/native_mem_model_if.sv
// rtl/native_mem_model_if.sv - picorv32 native memory bus bundle
// The master modport is the core side; the slave modport is the memory side.
interface native_mem_model_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/native_mem_model.sv
// rtl/native_mem_model.sv - picorv32 native-bus RAM/MMIO slave with wait states
// Define MEM_MODEL_MMIO_EN to decode the console/counter/done window at MMIO_BASE.
module native_mem_model #(
   parameter int          MEM_WORDS   = 256,
   parameter int          WAIT_CYCLES = 0,
   parameter string       INIT_FILE   = "",
   parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
   input  logic               clk,
   input  logic               resetn,
   native_mem_model_if.slave  bus,
   output logic               err,
   output logic [31:0]        err_addr,
   output logic               out_valid,
   output logic [7:0]         out_data,
   output logic               done
);

   localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
   localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] resp_data_q;

   logic [31:0] ram [MEM_WORDS];

   logic          accept, commit, req_write, ram_hit, in_range;
   logic [31:0]   req_addr, req_wdata, rd_word, mmio_rdata;
   logic [3:0]    req_wstrb;
   logic [AW-1:0] word_idx;
   logic          mmio_con, mmio_cnt, mmio_done;
   logic          unused_sig;

   // The cycle after a response still sees the core's mem_valid; never re-accept it.
   assign accept = (state == IDLE) && bus.mem_valid && !bus.mem_ready;
   assign commit = (accept && (WAIT_INIT == 8'd0)) ||
                   ((state == WAIT) && bus.mem_valid && (wait_cnt == 8'd1));

   assign req_addr  = (state == IDLE) ? bus.mem_addr  : addr_q;
   assign req_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;
   assign req_wstrb = (state == IDLE) ? bus.mem_wstrb : wstrb_q;
   assign req_write = |req_wstrb;
   assign ram_hit   = req_addr < RAM_BYTES;
   assign word_idx  = req_addr[AW+1:2];
   assign in_range  = ram_hit || mmio_con || mmio_cnt || mmio_done;
   assign rd_word   = ram_hit ? ram[word_idx] : mmio_rdata;

   assign unused_sig = ^{bus.mem_instr, MMIO_WORD};

`ifdef MEM_MODEL_MMIO_EN
   logic [31:0] cycle_cnt;
   logic        con_pend;

   assign mmio_con   = !ram_hit && (req_addr[31:2] == MMIO_WORD);
   assign mmio_cnt   = !ram_hit && (req_addr[31:2] == MMIO_WORD + 30'd1);
   assign mmio_done  = !ram_hit && (req_addr[31:2] == MMIO_WORD + 30'd2);
   assign mmio_rdata = mmio_cnt  ? cycle_cnt :
                       mmio_done ? {31'b0, done} : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cycle_cnt <= 32'h0;
         con_pend  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'h0;
         done      <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         out_valid <= (state == RESP) && con_pend;
         if (commit) begin
            con_pend <= mmio_con && req_write;
            if (mmio_con && req_write)  out_data <= req_wdata[7:0];
            if (mmio_done && req_write) done     <= 1'b1;
         end
      end
   end
`else
   assign mmio_con   = 1'b0;
   assign mmio_cnt   = 1'b0;
   assign mmio_done  = 1'b0;
   assign mmio_rdata = 32'h0;
   assign out_valid  = 1'b0;
   assign out_data   = 8'h0;
   assign done       = 1'b0;
`endif

   // Contents are deliberately not reset; read data was captured on the same edge.
   always_ff @(posedge clk) begin
      if (commit && ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wstrb[b]) ram[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         wait_cnt      <= 8'h0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         wstrb_q       <= 4'h0;
         resp_data_q   <= 32'h0;
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= 32'h0;
         err           <= 1'b0;
         err_addr      <= 32'h0;
      end else begin
         bus.mem_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q   <= bus.mem_addr;
                  wdata_q  <= bus.mem_wdata;
                  wstrb_q  <= bus.mem_wstrb;
                  wait_cnt <= WAIT_INIT;
                  state    <= (WAIT_INIT == 8'd0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (!bus.mem_valid)         state    <= IDLE;
               else if (wait_cnt == 8'd1)  state    <= RESP;
               else                        wait_cnt <= wait_cnt - 8'd1;
            end
            RESP: begin
               bus.mem_ready <= 1'b1;
               bus.mem_rdata <= resp_data_q;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (commit) begin
            resp_data_q <= in_range ? rd_word : 32'h0;
            if (!in_range && !err) begin
               err      <= 1'b1;
               err_addr <= req_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_native_mem_model.sv
// tb/tb_native_mem_model.sv - directed bench for native_mem_model
// Instance u0 runs with no wait states, u3 with three.
module tb_native_mem_model;

   logic clk;
   logic resetn;
   int   checks = 0;
   int   errors = 0;
   int   tb_cyc = 0;

   native_mem_model_if bus0 ();
   native_mem_model_if bus3 ();

   logic        err0, err3, ov0, ov3, done0, done3;
   logic [31:0] err_addr0, err_addr3;
   logic [7:0]  od0, od3;

   native_mem_model #(.MEM_WORDS(256), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .resetn(resetn), .bus(bus0.slave),
      .err(err0), .err_addr(err_addr0), .out_valid(ov0), .out_data(od0), .done(done0)
   );

   native_mem_model #(.MEM_WORDS(256), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .resetn(resetn), .bus(bus3.slave),
      .err(err3), .err_addr(err_addr3), .out_valid(ov3), .out_data(od3), .done(done3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel3, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
      bus0.mem_addr = a; bus0.mem_wdata = wd; bus0.mem_wstrb = ws;
      bus3.mem_addr = a; bus3.mem_wdata = wd; bus3.mem_wstrb = ws;
      if (sel3) bus3.mem_valid = v;
      else      bus0.mem_valid = v;
   endtask

   function automatic logic rdy(input bit sel3);
      return sel3 ? bus3.mem_ready : bus0.mem_ready;
   endfunction

   // Full core-style transfer: valid held until ready has been seen on an edge.
   task automatic xfer(input string tag, input bit sel3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output logic ov, output logic [7:0] od);
      int lat;
      lat = -1;
      rd  = 32'hx; ov = 1'bx; od = 8'hx;
      drive(sel3, 1'b1, a, wd, ws);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (rdy(sel3)) begin
            lat = c;
            rd  = sel3 ? bus3.mem_rdata : bus0.mem_rdata;
            ov  = sel3 ? ov3 : ov0;
            od  = sel3 ? od3 : od0;
            break;
         end
      end
      check({tag, " latency"}, 32'(lat), sel3 ? 32'd4 : 32'd1);
      @(posedge clk); #1;
      check({tag, " ready pulse width"}, {31'b0, rdy(sel3)}, 32'd0);
      drive(sel3, 1'b0, a, wd, 4'h0);
   endtask

   logic [31:0] rd, c1, c2;
   logic        ov;
   logic [7:0]  od;
   int          t1, t2;
   bit          saw;

   initial begin
      resetn = 1'b0;
      bus0.mem_instr = 1'b0; bus3.mem_instr = 1'b0;
      bus0.mem_valid = 1'b0; bus3.mem_valid = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset mem_ready", {31'b0, bus0.mem_ready}, 32'd0);
      check("reset mem_rdata", bus0.mem_rdata, 32'h0);
      check("reset err", {31'b0, err0}, 32'd0);
      check("reset err_addr", err_addr0, 32'h0);
      check("reset out_valid", {31'b0, ov0}, 32'd0);
      check("reset out_data", {24'b0, od0}, 32'h0);
      check("reset done", {31'b0, done0}, 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      xfer("w 3fc", 1'b0, 32'h0000_03FC, 32'h1234_5678, 4'hF, rd, ov, od);
      xfer("r 3fc", 1'b0, 32'h0000_03FC, 32'h0, 4'h0, rd, ov, od);
      check("r 3fc data", rd, 32'h1234_5678);
      check("err after in-range", {31'b0, err0}, 32'd0);

      xfer("w 10 full", 1'b0, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, rd, ov, od);
      xfer("w 10 lane1", 1'b0, 32'h0000_0010, 32'h0000_EE00, 4'b0010, rd, ov, od);
      check("w 10 lane1 pre-write data", rd, 32'hAABB_CCDD);
      xfer("r 10", 1'b0, 32'h0000_0010, 32'h0, 4'h0, rd, ov, od);
      check("r 10 data", rd, 32'hAABB_EEDD);

      xfer("u3 w 0", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, ov, od);
      xfer("u3 r 0", 1'b1, 32'h0, 32'h0, 4'h0, rd, ov, od);
      check("u3 r 0 data", rd, 32'hCAFE_F00D);

      drive(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      saw = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus3.mem_ready) saw = 1'b1;
      end
      check("abort no ready", {31'b0, saw}, 32'd0);
      xfer("u3 r 0 after abort", 1'b1, 32'h0, 32'h0, 4'h0, rd, ov, od);
      check("u3 r 0 after abort data", rd, 32'hCAFE_F00D);

      xfer("w 0", 1'b0, 32'h0, 32'h1111_2222, 4'hF, rd, ov, od);
      xfer("r 400", 1'b0, 32'h0000_0400, 32'h0, 4'h0, rd, ov, od);
      check("r 400 data", rd, 32'h0);
      check("r 400 err", {31'b0, err0}, 32'd1);
      check("r 400 err_addr", err_addr0, 32'h0000_0400);
      xfer("w 800", 1'b0, 32'h0000_0800, 32'h9999_8888, 4'hF, rd, ov, od);
      check("w 800 data", rd, 32'h0);
      check("w 800 err_addr sticky", err_addr0, 32'h0000_0400);
      xfer("r 0 after oor", 1'b0, 32'h0, 32'h0, 4'h0, rd, ov, od);
      check("r 0 after oor data", rd, 32'h1111_2222);

`ifdef MEM_MODEL_MMIO_EN
      xfer("console", 1'b0, 32'h1000_0000, 32'h0000_0041, 4'hF, rd, ov, od);
      check("console out_valid", {31'b0, ov}, 32'd1);
      check("console out_data", {24'b0, od}, 32'h41);
      check("console out_valid pulse", {31'b0, ov0}, 32'd0);
      xfer("cnt a", 1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, ov, od);
      c1 = rd; t1 = tb_cyc;
      repeat (7) @(posedge clk);
      #1;
      xfer("cnt b", 1'b0, 32'h1000_0004, 32'h0, 4'h0, rd, ov, od);
      c2 = rd; t2 = tb_cyc;
      check("counter delta", c2 - c1, 32'(t2 - t1));
      xfer("done r0", 1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, ov, od);
      check("done r0 data", rd, 32'h0);
      xfer("done w", 1'b0, 32'h1000_0008, 32'h0, 4'h1, rd, ov, od);
      check("done flag", {31'b0, done0}, 32'd1);
      xfer("done r1", 1'b0, 32'h1000_0008, 32'h0, 4'h0, rd, ov, od);
      check("done r1 data", rd, 32'h1);
`else
      xfer("u3 mmio", 1'b1, 32'h1000_0000, 32'h0000_0041, 4'hF, rd, ov, od);
      check("u3 mmio data", rd, 32'h0);
      check("u3 mmio out_valid", {31'b0, ov}, 32'd0);
      check("u3 mmio err", {31'b0, err3}, 32'd1);
      check("u3 mmio err_addr", err_addr3, 32'h1000_0000);
      check("u3 mmio done", {31'b0, done3}, 32'd0);
`endif

      drive(1'b1, 1'b1, 32'h0, 32'h5555_5555, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("rst mid-wait ready", {31'b0, bus3.mem_ready}, 32'd0);
      check("rst mid-wait rdata", bus3.mem_rdata, 32'h0);
      check("rst mid-wait err", {31'b0, err3}, 32'd0);
      check("rst mid-wait err_addr", err_addr3, 32'h0);
      check("rst mid-wait u0 err", {31'b0, err0}, 32'd0);
      check("rst mid-wait done", {31'b0, done0}, 32'd0);
      drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      xfer("u3 r 0 after reset", 1'b1, 32'h0, 32'h0, 4'h0, rd, ov, od);
      check("u3 r 0 after reset data", rd, 32'hCAFE_F00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
